// File: rtl/arb_mux_bus.sv
// arb_mux_bus: registered N-channel bus multiplexer with valid/ready on every
// input and on the output. The channel is chosen either explicitly via sel
// (mode 0) or by a round-robin search starting at ptr (mode 1). A drained
// word can be replaced by a new one in the same cycle, so the block sustains
// one transfer per clock while the consumer keeps outReady high.
module arb_mux_bus #(
  parameter int nrOfBits    = 8,
  parameter int nrOfSelBits = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic                                  mode,
  input  logic [nrOfSelBits-1:0]                sel,
  input  logic [(1 << nrOfSelBits)-1:0]          inValid,
  output logic [(1 << nrOfSelBits)-1:0]          inReady,
  input  logic [(1 << nrOfSelBits)*nrOfBits-1:0] muxIn,
  output logic [nrOfBits-1:0]                   muxOut,
  output logic                                  outValid,
  input  logic                                  outReady,
  output logic [nrOfSelBits-1:0]                outChannel
);

  localparam int W  = nrOfBits;
  localparam int SW = nrOfSelBits;
  localparam int N  = 1 << nrOfSelBits;

  // Output register and round-robin pointer.
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] chan_q, chan_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  // Arbitration results.
  logic [SW-1:0] cand_idx;
  logic          cand_ok;
  logic [SW-1:0] probe;
  logic          slot_free;
  logic          grant;

  // Unflattened view of the input data bus.
  logic [W-1:0]  ch_data [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi] = muxIn[gi*W +: W];
      // Ready is a one-hot copy of the grant; it never looks at muxIn.
      assign inReady[gi] = grant && (cand_idx == SW'(gi));
    end
  endgenerate

  // Candidate selection: explicit sel, or first valid channel from ptr upward.
  always_comb begin
    cand_idx = sel;
    cand_ok  = 1'b0;
    probe    = '0;
    if (!mode) begin
      cand_ok = inValid[sel];
    end else begin
      // Walk offsets from farthest to nearest so the nearest valid one wins.
      for (int k = N - 1; k >= 0; k--) begin
        probe = ptr_q + SW'(k);
        if (inValid[probe]) begin
          cand_idx = probe;
          cand_ok  = 1'b1;
        end
      end
    end
  end

  // Grant when enabled, the output slot frees up this cycle, and a candidate
  // exists. Reset forces all ready bits low even before the first edge.
  assign slot_free = !valid_q || outReady;
  assign grant     = reset_n && enable && slot_free && cand_ok;

  // Next-state for the output register and pointer.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (grant) begin
      data_d  = ch_data[cand_idx];
      chan_d  = cand_idx;
      valid_d = 1'b1;
      if (mode) begin
        ptr_d = cand_idx + SW'(1);
      end
    end else if (outReady) begin
      valid_d = 1'b0;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Data reads zero whenever the register is empty; the channel index stays.
  assign muxOut     = valid_q ? data_q : '0;
  assign outValid   = valid_q;
  assign outChannel = chan_q;

endmodule

// File: tb/tb_arb_mux_bus.sv
// Bench for arb_mux_bus (8-bit data, 4 channels). A transaction-level model
// tracks the held word and the round-robin pointer; every cycle the DUT's
// ready vector and registered outputs are compared with it. Directed
// sequences also pin literal values so a wrong model cannot hide a bug.
module tb_arb_mux_bus;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  inValid;
  logic [3:0]  inReady;
  logic [31:0] muxIn;
  logic [7:0]  muxOut;
  logic        outValid;
  logic        outReady;
  logic [1:0]  outChannel;

  arb_mux_bus #(.nrOfBits(8), .nrOfSelBits(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .mode       (mode),
    .sel        (sel),
    .inValid    (inValid),
    .inReady    (inReady),
    .muxIn      (muxIn),
    .muxOut     (muxOut),
    .outValid   (outValid),
    .outReady   (outReady),
    .outChannel (outChannel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: one held word plus the arbitration pointer.
  bit       m_valid;
  bit [7:0] m_data;
  int       m_chan;
  int       m_ptr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  // One clock cycle: drive inputs, check ready, clock, check registered outputs.
  task automatic apply(input bit en, input bit md, input logic [1:0] sl,
                       input logic [3:0] iv, input bit ordy, input logic [31:0] din);
    bit          has;
    bit          grant;
    int          cand;
    int          idx;
    logic [3:0]  exp_rdy;
    logic [7:0]  slice;
    enable   = en;
    mode     = md;
    sel      = sl;
    inValid  = iv;
    outReady = ordy;
    muxIn    = din;
    has  = 1'b0;
    cand = 0;
    if (!md) begin
      cand = int'(sl);
      has  = iv[cand];
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (!has && iv[idx]) begin
          has  = 1'b1;
          cand = idx;
        end
      end
    end
    grant   = en && (!m_valid || ordy) && has;
    exp_rdy = grant ? (4'b0001 << cand) : 4'b0000;
    #1;
    cmp("inReady", {28'd0, inReady}, {28'd0, exp_rdy});
    @(posedge clock);
    if (grant) begin
      slice   = din[cand*8 +: 8];
      m_data  = slice;
      m_chan  = cand;
      m_valid = 1'b1;
      if (md) m_ptr = (cand + 1) % 4;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    vectors++;
    cmp("outValid", {31'd0, outValid}, {31'd0, m_valid});
    cmp("muxOut", {24'd0, muxOut}, m_valid ? {24'd0, m_data} : 32'd0);
    cmp("outChannel", {30'd0, outChannel}, m_chan);
    $display("cyc %0d en=%0b md=%0b sel=%0d iv=%b ordy=%0b rdy=%b -> ov=%0b out=%02h ch=%0d",
             vectors, en, md, sl, iv, ordy, inReady, outValid, muxOut, outChannel);
  endtask

  localparam logic [31:0] DIN_A = 32'h40302010;

  logic [7:0] held;

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    mode     = 1'b0;
    sel      = 2'd0;
    inValid  = 4'b0000;
    outReady = 1'b0;
    muxIn    = 32'd0;
    model_reset();
    #12;
    cmp("reset_outValid", {31'd0, outValid}, 32'd0);
    cmp("reset_muxOut", {24'd0, muxOut}, 32'd0);
    cmp("reset_outChannel", {30'd0, outChannel}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Explicit select: sel=2 always wins, data 0x30 every cycle.
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 2'd2, 4'b1111, 1, DIN_A);
      cmp("sel2_ready", {28'd0, inReady}, 32'b0100);
      cmp("sel2_data", {24'd0, muxOut}, 32'h30);
      cmp("sel2_chan", {30'd0, outChannel}, 32'd2);
    end

    // Round-robin sequence 0,1,2,3,0,1,2,3 with no bubble (ptr still 0).
    for (int i = 0; i < 8; i++) begin
      apply(1, 1, 2'd0, 4'b1111, 1, DIN_A);
      cmp("rr_chan", {30'd0, outChannel}, i % 4);
      cmp("rr_valid", {31'd0, outValid}, 32'd1);
    end

    // Skipping: force ptr=3 via a grant to ch2, then 0110 gives ch1 then ch2.
    apply(1, 1, 2'd0, 4'b0100, 1, DIN_A);
    cmp("skip_setup_chan", {30'd0, outChannel}, 32'd2);
    apply(1, 1, 2'd0, 4'b0110, 1, DIN_A);
    cmp("skip_first", {30'd0, outChannel}, 32'd1);
    cmp("skip_ptr_model", m_ptr, 32'd2);
    apply(1, 1, 2'd0, 4'b0110, 1, DIN_A);
    cmp("skip_second", {30'd0, outChannel}, 32'd2);
    cmp("skip_data", {24'd0, muxOut}, 32'h30);

    // Backpressure: word held, no ready for 5 cycles, then drain+accept.
    held = muxOut;
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 2'd0, 4'b1111, 0, DIN_A);
      cmp("bp_ready", {28'd0, inReady}, 32'd0);
      cmp("bp_stable", {24'd0, muxOut}, {24'd0, held});
    end
    apply(1, 1, 2'd0, 4'b1111, 1, DIN_A);
    cmp("bp_release_valid", {31'd0, outValid}, 32'd1);
    cmp("bp_release_chan", {30'd0, outChannel}, 32'd3);

    // Enable gating: hold 0x77, then drain it with enable low.
    apply(1, 0, 2'd1, 4'b1111, 1, 32'h00007700);
    cmp("en_hold", {24'd0, muxOut}, 32'h77);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 2'd1, 4'b1111, 1, 32'h00007700);
      cmp("en_ready", {28'd0, inReady}, 32'd0);
      cmp("en_drained", {24'd0, muxOut}, 32'd0);
    end

    // Asynchronous reset mid-transfer while holding 0x5A on ch1.
    apply(1, 0, 2'd1, 4'b1111, 1, 32'h00005A00);
    cmp("pre_reset_data", {24'd0, muxOut}, 32'h5A);
    enable   = 1'b1;
    mode     = 1'b1;
    inValid  = 4'b1111;
    outReady = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    cmp("async_outValid", {31'd0, outValid}, 32'd0);
    cmp("async_muxOut", {24'd0, muxOut}, 32'd0);
    cmp("async_outChannel", {30'd0, outChannel}, 32'd0);
    cmp("async_inReady", {28'd0, inReady}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    apply(1, 1, 2'd3, 4'b1111, 1, DIN_A);
    cmp("post_reset_chan", {30'd0, outChannel}, 32'd0);
    cmp("post_reset_data", {24'd0, muxOut}, 32'h10);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      apply($urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0,
            $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
